// File: rtl/router_pkg.sv
// Shared definitions for the router packet generator and receive-side blocks.
package router_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'd3;

    // Feedback taps for the payload LFSR: bits 7, 5, 4 and 3.
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_DONE
    } pkt_state_e;

    // Header byte layout: {payload_len, dest_addr}.
    function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

    // One step of the payload LFSR: shift left, feedback into bit 0.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] cur);
        return {cur[DATA_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/router_pkt_gen_if.sv
// Byte stream into the router input port: data plus valid, with busy back-pressure.
interface router_pkt_gen_if;

    logic                          pkt_valid;
    logic [router_pkg::DATA_W-1:0] data_out;
    logic                          busy;

    modport master (output pkt_valid, output data_out, input  busy);
    modport slave  (input  pkt_valid, input  data_out, output busy);

endinterface

// File: rtl/router_payload_pat.sv
// Payload byte generator: incrementing counter or 8-bit LFSR, loaded from a seed.
module router_payload_pat
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              mode_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] byte_o
);

    logic [DATA_W-1:0] pat_q, pat_d;
    logic              mode_q, mode_d;

    // Next pattern value: load seed (LFSR never starts at zero), or step.
    always_comb begin
        pat_d  = pat_q;
        mode_d = mode_q;
        if (load_i) begin
            mode_d = mode_i;
            pat_d  = (mode_i && (seed_i == '0)) ? DATA_W'(1) : seed_i;
        end else if (advance_i) begin
            pat_d = mode_q ? lfsr_next(pat_q) : (pat_q + DATA_W'(1));
        end
    end

    // Pattern register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pat_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_d;
        end
    end

    assign byte_o = pat_q;

endmodule

// File: rtl/router_pkt_gen.sv
// Router packet transmitter: header, payload bytes, then XOR parity byte.
module router_pkt_gen
    import router_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   dest_addr_i,
    input  logic [LEN_W-1:0]    payload_len_i,
    input  logic [DATA_W-1:0]   seed_i,
    input  logic                mode_i,
    input  logic                inject_err_i,
    router_pkt_gen_if.master    tx,
    output logic                tx_active_o,
    output logic                done_o,
    output logic                cfg_err_o,
    output logic [CNT_W-1:0]    pkt_count_o
);

    pkt_state_e         state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               tx_active_q, tx_active_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  parity_q, parity_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;

    logic               pat_load;
    logic               pat_adv;
    logic [DATA_W-1:0]  pat_byte;

    router_payload_pat u_pat (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (pat_load),
        .seed_i    (seed_i),
        .mode_i    (mode_i),
        .advance_i (pat_adv),
        .byte_o    (pat_byte)
    );

    // Next-state and registered-output logic; busy freezes every transfer step.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = valid_q;
        tx_active_d = tx_active_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        remain_d    = remain_q;
        len_d       = len_q;
        err_d       = err_q;
        pat_load    = 1'b0;
        pat_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d     = 1'b0;
                data_d      = '0;
                tx_active_d = 1'b0;
                if (start_i) begin
                    if ((dest_addr_i == ILLEGAL_ADDR) || (payload_len_i == '0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        len_d       = payload_len_i;
                        err_d       = inject_err_i;
                        pat_load    = 1'b1;
                        parity_d    = '0;
                        data_d      = pack_header(payload_len_i, dest_addr_i);
                        valid_d     = 1'b1;
                        tx_active_d = 1'b1;
                        state_d     = ST_HEADER;
                    end
                end
            end

            ST_HEADER: begin
                if (!tx.busy) begin
                    parity_d = parity_q ^ data_q;
                    data_d   = pat_byte;
                    pat_adv  = 1'b1;
                    remain_d = len_q;
                    state_d  = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (!tx.busy) begin
                    parity_d = parity_q ^ data_q;
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        // Parity byte folds in the byte being transferred this edge.
                        data_d  = parity_q ^ data_q ^ {{(DATA_W-1){1'b0}}, err_q};
                        valid_d = 1'b0;
                        state_d = ST_PARITY;
                    end else begin
                        data_d  = pat_byte;
                        pat_adv = 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (!tx.busy) begin
                    data_d      = '0;
                    valid_d     = 1'b0;
                    tx_active_d = 1'b0;
                    done_d      = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                data_d      = '0;
                valid_d     = 1'b0;
                tx_active_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                data_d      = '0;
                valid_d     = 1'b0;
                tx_active_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            cnt_q       <= '0;
            parity_q    <= '0;
            remain_q    <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            remain_q    <= remain_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

    assign tx.pkt_valid  = valid_q;
    assign tx.data_out   = data_q;
    assign tx_active_o   = tx_active_q;
    assign done_o        = done_q;
    assign cfg_err_o     = cfg_err_q;
    assign pkt_count_o   = cnt_q;

endmodule
